// File: rtl/aosi_pcie_packer_pkg.sv
// Shared types and constants for the AmorphOS PCI-E sub-packet packer.
package aosi_pcie_packer_pkg;

    localparam int F1_PCIE_HDR_SLOT_W   = 16;
    localparam int F1_PCIE_SUB_W        = 128;
    localparam int F1_PCIE_MAX_SUB      = 3;
    localparam int F1_PCIE_PKT_W        = 512;
    localparam int F1_PCIE_HDR_W        = 40;
    localparam int F1_pcie_pack_timeout = 64;

    typedef struct packed {
        logic                          valid;
        logic [F1_PCIE_SUB_W-1:0]      data;
        logic [F1_PCIE_HDR_SLOT_W-1:0] slot;
        logic                          last;
    } PCIEPacket;

    // Header layout from LSB: slot, count, valid vector, last vector.
    typedef struct packed {
        logic [7:0]                    last_vec;
        logic [7:0]                    valid_vec;
        logic [7:0]                    count;
        logic [F1_PCIE_HDR_SLOT_W-1:0] slot;
    } pcie_pack_hdr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_FLUSH
    } acc_state_e;

endpackage

// File: rtl/aosi_pcie_packer_if.sv
// Sub-packet input and bundle output handshake between arbiter, packer and PCIM engine.
interface aosi_pcie_packer_if;
    import aosi_pcie_packer_pkg::*;

    PCIEPacket                packet_from_aosi;
    logic                     packet_from_aosi_grant;
    logic [F1_PCIE_PKT_W-1:0] packet_to_pcim;
    logic                     packet_to_pcim_valid;
    logic                     packet_to_pcim_grant;

    modport slave (
        input  packet_from_aosi,
        input  packet_to_pcim_grant,
        output packet_from_aosi_grant,
        output packet_to_pcim,
        output packet_to_pcim_valid
    );

    modport master (
        output packet_from_aosi,
        output packet_to_pcim_grant,
        input  packet_from_aosi_grant,
        input  packet_to_pcim,
        input  packet_to_pcim_valid
    );

endinterface

// File: rtl/aosi_pcie_bundle_acc.sv
// Bundle accumulator: gathers same-slot sub-packets and closes on last, full,
// slot change or idle timeout; o_close marks the edge a bundle is written out.
module aosi_pcie_bundle_acc
    import aosi_pcie_packer_pkg::*;
#(
    parameter int NUM_SUB        = 3,
    parameter int TIMEOUT_CYCLES = F1_pcie_pack_timeout
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  PCIEPacket                i_pkt,
    input  logic                     i_ready,
    output logic                     o_grant,
    output logic                     o_close,
    output logic                     o_timeout,
    output logic [F1_PCIE_PKT_W-1:0] o_bundle
);

    localparam int          H         = NUM_SUB * F1_PCIE_SUB_W;
    localparam logic [7:0]  NUM_SUB_B = 8'(NUM_SUB);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic [NUM_SUB-1:0][F1_PCIE_SUB_W-1:0] data;
        logic [F1_PCIE_HDR_SLOT_W-1:0]         slot;
        logic [7:0]                            count;
        logic [NUM_SUB-1:0]                    vvec;
        logic [NUM_SUB-1:0]                    lvec;
    } acc_t;

    acc_state_e               r_state, w_state_nxt;
    acc_t                     r_acc, w_acc_nxt, w_fresh, w_src;
    logic [31:0]              r_timer, w_timer_nxt;
    logic                     w_grant, w_close, w_timeout, w_emit_nxt;
    pcie_pack_hdr_t           w_hdr;
    logic [F1_PCIE_PKT_W-1:0] w_bundle;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_timer_nxt = r_timer;
        w_grant     = 1'b0;
        w_close     = 1'b0;
        w_timeout   = 1'b0;
        w_emit_nxt  = 1'b0;

        w_fresh         = '0;
        w_fresh.data[0] = i_pkt.data;
        w_fresh.slot    = i_pkt.slot;
        w_fresh.count   = 8'd1;
        w_fresh.vvec[0] = 1'b1;
        w_fresh.lvec[0] = i_pkt.last;

        case (r_state)
            ST_IDLE: begin
                if (i_pkt.valid) begin
                    w_grant     = 1'b1;
                    w_acc_nxt   = w_fresh;
                    w_timer_nxt = '0;
                    if (i_pkt.last || NUM_SUB == 1) begin
                        w_emit_nxt  = 1'b1;
                        w_close     = i_ready;
                        w_state_nxt = i_ready ? ST_IDLE : ST_FLUSH;
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end
            end

            ST_FILL: begin
                if (i_pkt.valid && i_pkt.slot == r_acc.slot) begin
                    w_grant     = 1'b1;
                    w_timer_nxt = '0;
                    for (int i = 0; i < NUM_SUB; i++) begin
                        if (i == int'(r_acc.count)) begin
                            w_acc_nxt.data[i] = i_pkt.data;
                            w_acc_nxt.vvec[i] = 1'b1;
                            w_acc_nxt.lvec[i] = i_pkt.last;
                        end
                    end
                    w_acc_nxt.count = r_acc.count + 8'd1;
                    if (i_pkt.last || w_acc_nxt.count == NUM_SUB_B) begin
                        w_emit_nxt  = 1'b1;
                        w_close     = i_ready;
                        w_state_nxt = i_ready ? ST_IDLE : ST_FLUSH;
                    end
                end else if (i_pkt.valid) begin
                    // Slot change: the held bundle goes out and the new sub only enters if that push lands.
                    if (i_ready) begin
                        w_grant     = 1'b1;
                        w_close     = 1'b1;
                        w_acc_nxt   = w_fresh;
                        w_timer_nxt = '0;
                        w_state_nxt = (i_pkt.last || NUM_SUB == 1) ? ST_FLUSH : ST_FILL;
                    end else begin
                        w_state_nxt = ST_FLUSH;
                    end
                end else if (TIMEOUT_CYCLES != 0 && r_timer == TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_close     = i_ready;
                    w_state_nxt = i_ready ? ST_IDLE : ST_FLUSH;
                end else begin
                    w_timer_nxt = r_timer + 32'd1;
                end
            end

            ST_FLUSH: begin
                if (i_ready) begin
                    w_close     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A bundle closing on the accept edge carries the incoming sub; otherwise the held one goes out.
    always_comb begin
        w_src           = w_emit_nxt ? w_acc_nxt : r_acc;
        w_hdr           = '0;
        w_hdr.slot      = w_src.slot;
        w_hdr.count     = w_src.count;
        w_hdr.valid_vec = 8'(w_src.vvec);
        w_hdr.last_vec  = 8'(w_src.lvec);
        w_bundle        = '0;
        for (int i = 0; i < NUM_SUB; i++) begin
            w_bundle[i*F1_PCIE_SUB_W +: F1_PCIE_SUB_W] = w_src.data[i];
        end
        w_bundle[H +: F1_PCIE_HDR_W] = w_hdr;
    end

    assign o_grant   = w_grant;
    assign o_close   = w_close;
    assign o_timeout = w_timeout;
    assign o_bundle  = w_bundle;

endmodule

// File: rtl/aosi_pcie_packer.sv
// Packs AmorphOS PCI-E sub-packets into 512-bit F1 bundles, queues them in an
// output FIFO for the PCIM write engine and keeps running statistics.
module aosi_pcie_packer
    import aosi_pcie_packer_pkg::*;
#(
    parameter int NUM_SUB        = 3,
    parameter int TIMEOUT_CYCLES = F1_pcie_pack_timeout,
    parameter int OUT_LOG_DEPTH  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    aosi_pcie_packer_if.slave        bus,
    output logic [31:0]              stat_bundles,
    output logic [31:0]              stat_subpkts,
    output logic [15:0]              stat_timeouts
);

    localparam int DEPTH = 1 << OUT_LOG_DEPTH;

    logic                     w_grant, w_close, w_timeout, w_pop, w_full, w_empty;
    logic [F1_PCIE_PKT_W-1:0] w_bundle;
    logic [OUT_LOG_DEPTH:0]   r_wr_ptr, r_rd_ptr;
    logic [F1_PCIE_PKT_W-1:0] r_mem [DEPTH];
    logic [31:0]              r_stat_bundles, r_stat_subpkts;
    logic [15:0]              r_stat_timeouts;

    aosi_pcie_bundle_acc #(
        .NUM_SUB        (NUM_SUB),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_pkt     (bus.packet_from_aosi),
        .i_ready   (!w_full),
        .o_grant   (w_grant),
        .o_close   (w_close),
        .o_timeout (w_timeout),
        .o_bundle  (w_bundle)
    );

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[OUT_LOG_DEPTH] != r_rd_ptr[OUT_LOG_DEPTH]) &&
                     (r_wr_ptr[OUT_LOG_DEPTH-1:0] == r_rd_ptr[OUT_LOG_DEPTH-1:0]);
    assign w_pop   = !w_empty && bus.packet_to_pcim_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_close) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: bundle storage is deliberately not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_close) r_mem[r_wr_ptr[OUT_LOG_DEPTH-1:0]] <= w_bundle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_bundles  <= '0;
            r_stat_subpkts  <= '0;
            r_stat_timeouts <= '0;
        end else begin
            if (w_close) r_stat_bundles <= r_stat_bundles + 32'd1;
            if (w_grant) r_stat_subpkts <= r_stat_subpkts + 32'd1;
            if (w_timeout && r_stat_timeouts != 16'hFFFF) r_stat_timeouts <= r_stat_timeouts + 16'd1;
        end
    end

    assign bus.packet_from_aosi_grant = w_grant;
    assign bus.packet_to_pcim_valid   = !w_empty;
    assign bus.packet_to_pcim         = w_empty ? '0 : r_mem[r_rd_ptr[OUT_LOG_DEPTH-1:0]];
    assign stat_bundles               = r_stat_bundles;
    assign stat_subpkts               = r_stat_subpkts;
    assign stat_timeouts              = r_stat_timeouts;

endmodule

// File: tb/tb_aosi_pcie_packer.sv
// Scoreboard bench: a queue-based bundling model predicts every bundle; a monitor checks the output stream.
module tb_aosi_pcie_packer;
    import aosi_pcie_packer_pkg::*;

    localparam int NSUB = 3;
    localparam int TO   = 16;
    localparam int LD   = 3;
    localparam int H    = NSUB * 128;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] stat_bundles, stat_subpkts;
    logic [15:0] stat_timeouts;

    aosi_pcie_packer_if bus ();

    aosi_pcie_packer #(
        .NUM_SUB        (NSUB),
        .TIMEOUT_CYCLES (TO),
        .OUT_LOG_DEPTH  (LD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .stat_bundles  (stat_bundles),
        .stat_subpkts  (stat_subpkts),
        .stat_timeouts (stat_timeouts)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int cons_mode = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: bundles built straight from the sub-packet stream.
    logic [511:0] exp_q[$];
    logic [15:0]  m_slot;
    logic [127:0] m_data[$];
    bit           m_last[$];
    int           m_bundles, m_subpkts, m_timeouts;

    function automatic void model_emit();
        logic [511:0] b  = '0;
        logic [7:0]   vv = '0;
        logic [7:0]   lv = '0;
        for (int i = 0; i < m_data.size(); i++) begin
            b[i*128 +: 128] = m_data[i];
            vv[i] = 1'b1;
            lv[i] = m_last[i];
        end
        b[H +: 16]    = m_slot;
        b[H+16 +: 8]  = 8'(m_data.size());
        b[H+24 +: 8]  = vv;
        b[H+32 +: 8]  = lv;
        exp_q.push_back(b);
        m_bundles++;
        m_data.delete();
        m_last.delete();
    endfunction

    function automatic void model_accept(input logic [15:0] slot, input logic [127:0] data, input bit last);
        m_subpkts++;
        if (m_data.size() > 0 && slot != m_slot) model_emit();
        if (m_data.size() == 0) m_slot = slot;
        m_data.push_back(data);
        m_last.push_back(last);
        if (last || m_data.size() == NSUB) model_emit();
    endfunction

    // Consumer: 0 = hold off, 1 = always take, 2 = random back-pressure.
    initial begin
        bus.packet_to_pcim_grant = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (cons_mode)
                0:       bus.packet_to_pcim_grant = 1'b0;
                1:       bus.packet_to_pcim_grant = 1'b1;
                default: bus.packet_to_pcim_grant = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares each dequeued bundle against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.packet_to_pcim_valid && bus.packet_to_pcim_grant) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_bundle: got %0h expected none", bus.packet_to_pcim);
                    end else begin
                        check("bundle", bus.packet_to_pcim, exp_q.pop_front());
                    end
                end else if (!bus.packet_to_pcim_valid) begin
                    check("idle_zero", bus.packet_to_pcim, '0);
                end
                if (!bus.packet_from_aosi.valid) check("grant_no_valid", 512'(bus.packet_from_aosi_grant), '0);
            end
        end
    end

    int last_acc_cyc;

    // Offers one sub until granted (bounded); entered and left at posedge+1.
    task automatic send_sub(input logic [15:0] slot, input logic [127:0] data, input bit last,
                            output int waited);
        bit done = 1'b0;
        waited = -1;
        bus.packet_from_aosi = '{valid: 1'b1, data: data, slot: slot, last: last};
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (bus.packet_from_aosi_grant) begin
                @(posedge clk);
                model_accept(slot, data, last);
                done   = 1'b1;
                waited = k;
            end
        end
        #1;
        last_acc_cyc = cyc;
        bus.packet_from_aosi = '0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no grant expected grant for slot %0h", slot);
        end
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.packet_to_pcim_valid) ok = 1'b1;
        end
        check("drain", 512'(exp_q.size()), '0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_stat_bundles"},  stat_bundles,  512'(m_bundles));
        check({tag, "_stat_subpkts"},  stat_subpkts,  512'(m_subpkts));
        check({tag, "_stat_timeouts"}, stat_timeouts, 512'(m_timeouts));
    endtask

    initial begin
        int w;
        int w2;
        bus.packet_from_aosi = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 512'(bus.packet_to_pcim_valid), '0);
        check("rst_data", bus.packet_to_pcim, '0);
        check("rst_grant", 512'(bus.packet_from_aosi_grant), '0);
        check_stats("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single last sub: one-cycle latency to valid
        send_sub(16'd5, 128'hA, 1'b1, w);
        check("single_latency", 512'(bus.packet_to_pcim_valid), 512'd1);
        wait_drain();
        check_stats("single");

        // Three same-slot subs fill a bundle
        send_sub(16'd2, 128'h21, 1'b0, w);
        send_sub(16'd2, 128'h22, 1'b0, w);
        send_sub(16'd2, 128'h23, 1'b0, w);
        wait_drain();
        check_stats("full3");

        // Slot change splits with grant held
        send_sub(16'd2, 128'h2222, 1'b0, w);
        send_sub(16'd7, 128'h7777, 1'b1, w2);
        check("split_grant_a", 512'(w), '0);
        check("split_grant_b", 512'(w2), '0);
        wait_drain();
        check_stats("split");

        // Idle timeout closes a partial bundle TO cycles after the accept
        send_sub(16'd4, 128'h44, 1'b0, w);
        model_emit();
        m_timeouts++;
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 40 && !seen; k++) begin
                @(negedge clk);
                if (bus.packet_to_pcim_valid) seen = 1'b1;
            end
            check("timeout_latency", 512'(cyc - last_acc_cyc), 512'(TO));
        end
        wait_drain();
        check_stats("timeout");

        // FIFO full: eight bundles stall, ninth parks, tenth is refused until drain
        cons_mode = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) send_sub(16'(10 + i), {$urandom, $urandom, $urandom, $urandom}, 1'b1, w);
        bus.packet_from_aosi = '{valid: 1'b1, data: 128'h1919, slot: 16'd19, last: 1'b1};
        repeat (4) begin
            @(negedge clk);
            check("flush_grant", 512'(bus.packet_from_aosi_grant), '0);
        end
        check("flush_stat_bundles", stat_bundles, 512'(m_bundles - 1));
        cons_mode = 1;
        @(posedge clk);
        #1;
        send_sub(16'd19, 128'h1919, 1'b1, w);
        wait_drain();
        check_stats("full");

        // Reset with two subs held discards them
        send_sub(16'd3, 128'h31, 1'b0, w);
        send_sub(16'd3, 128'h32, 1'b0, w);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        m_data.delete();
        m_last.delete();
        m_bundles  = 0;
        m_subpkts  = 0;
        m_timeouts = 0;
        #1;
        check("midrst_valid", 512'(bus.packet_to_pcim_valid), '0);
        check_stats("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_sub(16'd9, 128'h99, 1'b1, w);
        wait_drain();
        check_stats("postrst");

        // Randomised traffic with consumer back-pressure
        cons_mode = 2;
        for (int n = 0; n < 300; n++) begin
            int g = $urandom_range(0, 3);
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            send_sub(16'($urandom_range(0, 3)), {$urandom, $urandom, $urandom, $urandom},
                     (n == 299) ? 1'b1 : ($urandom_range(0, 3) == 0), w);
        end
        cons_mode = 1;
        wait_drain();
        check_stats("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
